// File: rtl/ltc2666_msg_arbiter.sv
// Round-robin arbiter feeding the single message port of ltc2666_controller.
// Grants are held until the controller reports done. An over-temperature
// interrupt queues a power-down command that is issued ahead of any pending
// request. A watchdog abandons transactions the controller never finishes.
//
// state | meaning
// IDLE  | no message outstanding; emergency capture or round-robin grant
// ISSUE | msg_valid_o high, waiting for the controller handshake
// WAIT  | message accepted, waiting for ctrl_done_i
module ltc2666_msg_arbiter #(
  parameter int         NUM_REQ          = 4,
  parameter int         TIMEOUT_CC       = 4096,
  parameter logic [3:0] EMERG_CMD        = 4'b0101,
  parameter bit         LOCK_AFTER_EMERG = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [4*NUM_REQ-1:0]       req_cmd_i,
  input  logic [8*NUM_REQ-1:0]       req_mask_i,
  input  logic [16*NUM_REQ-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]         req_done_o,
  output logic [NUM_REQ-1:0]         req_err_o,
  output logic                       msg_valid_o,
  input  logic                       msg_ready_i,
  output logic [3:0]                 msg_cmd_o,
  output logic [7:0]                 msg_chan_mask_o,
  output logic [15:0]                msg_data_o,
  input  logic                       ctrl_done_i,
  input  logic                       ctrl_err_echo_i,
  input  logic                       ctrl_err_illegal_i,
  input  logic                       ovrtmp_irq_i,
  input  logic                       clear_i,
  output logic                       emerg_pending_o,
  output logic                       emerg_done_o,
  output logic                       blocked_o,
  output logic                       timeout_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 own_emerg_q, own_emerg_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [7:0]           mask_q, mask_d;
  logic [15:0]          data_q, data_d;
  logic [1:0]           err_base_q, err_base_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 blocked_q, blocked_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 edone_q, edone_d;

  logic [3:0]           cmd_arr  [NUM_REQ];
  logic [7:0]           mask_arr [NUM_REQ];
  logic [15:0]          data_arr [NUM_REQ];

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        rr_sel;
  int                   rr_idx;

  logic                 cap_emerg;
  logic                 fin_emerg;
  logic                 wd_set;
  logic                 wd_hit;
  logic                 emerg_in_flight;
  logic [1:0]           err_now;

  // Unpack the flat requester buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_arr[i]  = req_cmd_i[4*i +: 4];
      mask_arr[i] = req_mask_i[8*i +: 8];
      data_arr[i] = req_data_i[16*i +: 16];
    end
  end

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    rr_sel    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(ptr_q) + k) % NUM_REQ;
      rr_sel = rr_idx[IW-1:0];
      if (!win_found && req_valid_i[rr_sel]) begin
        win_found = 1'b1;
        win_idx   = rr_sel;
      end
    end
  end

  assign wd_hit          = (cnt_q == CW'(TIMEOUT_CC - 2));
  assign emerg_in_flight = own_emerg_q && (state_q != IDLE);
  assign err_now         = {ctrl_err_echo_i, ctrl_err_illegal_i};

  // Next-state logic, capture, completion and watchdog handling.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    own_emerg_d = own_emerg_q;
    cmd_d       = cmd_q;
    mask_d      = mask_q;
    data_d      = data_q;
    err_base_d  = err_base_q;
    cnt_d       = cnt_q;
    done_d      = '0;
    err_d       = '0;
    edone_d     = 1'b0;
    req_ready_o = '0;
    cap_emerg   = 1'b0;
    fin_emerg   = 1'b0;
    wd_set      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q || ovrtmp_irq_i) begin
          cap_emerg   = 1'b1;
          own_emerg_d = 1'b1;
          cmd_d       = EMERG_CMD;
          mask_d      = '0;
          data_d      = '0;
          cnt_d       = '0;
          state_d     = ISSUE;
        end else if (!blocked_q && win_found && !rst_i) begin
          req_ready_o[win_idx] = 1'b1;
          ptr_d       = win_idx;
          owner_d     = win_idx;
          own_emerg_d = 1'b0;
          cmd_d       = cmd_arr[win_idx];
          mask_d      = mask_arr[win_idx];
          data_d      = data_arr[win_idx];
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (wd_hit) begin
          // Expiry wins over a simultaneous handshake: the message is dropped.
          wd_set  = 1'b1;
          state_d = IDLE;
          if (own_emerg_q) begin
            edone_d   = 1'b1;
            fin_emerg = 1'b1;
          end else begin
            err_d[owner_q] = 1'b1;
          end
        end else if (msg_ready_i) begin
          err_base_d = err_now;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (ctrl_done_i) begin
          state_d = IDLE;
          if (own_emerg_q) begin
            edone_d   = 1'b1;
            fin_emerg = 1'b1;
          end else begin
            done_d[owner_q] = 1'b1;
            err_d[owner_q]  = |(err_now & ~err_base_q);
          end
        end else if (wd_hit) begin
          wd_set  = 1'b1;
          state_d = IDLE;
          if (own_emerg_q) begin
            edone_d   = 1'b1;
            fin_emerg = 1'b1;
          end else begin
            err_d[owner_q] = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Sticky flags; a set event outranks clear_i in the same cycle.
  always_comb begin
    pend_d    = pend_q;
    blocked_d = blocked_q;
    timeout_d = timeout_q;
    if (cap_emerg) begin
      pend_d = 1'b0;
    end else if (ovrtmp_irq_i && !emerg_in_flight) begin
      pend_d = 1'b1;
    end
    if (fin_emerg && LOCK_AFTER_EMERG) begin
      blocked_d = 1'b1;
    end else if (clear_i) begin
      blocked_d = 1'b0;
    end
    if (wd_set) begin
      timeout_d = 1'b1;
    end else if (clear_i) begin
      timeout_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      owner_q     <= '0;
      own_emerg_q <= 1'b0;
      cmd_q       <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      err_base_q  <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      blocked_q   <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      edone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      own_emerg_q <= own_emerg_d;
      cmd_q       <= cmd_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      err_base_q  <= err_base_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      blocked_q   <= blocked_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      err_q       <= err_d;
      edone_q     <= edone_d;
    end
  end

  assign msg_valid_o     = (state_q == ISSUE);
  assign msg_cmd_o       = cmd_q;
  assign msg_chan_mask_o = mask_q;
  assign msg_data_o      = data_q;
  assign req_done_o      = done_q;
  assign req_err_o       = err_q;
  assign emerg_done_o    = edone_q;
  assign emerg_pending_o = pend_q;
  assign blocked_o       = blocked_q;
  assign timeout_o       = timeout_q;
  assign owner_o         = owner_q;

endmodule

// File: doc/ltc2666_msg_arbiter.md
# ltc2666_msg_arbiter

Shares the single message port of `ltc2666_controller` among `NUM_REQ` independent requesters using round-robin arbitration. Holds each granted message until the controller reports `done_o`. Injects a priority power-down command when an over-temperature interrupt fires. A watchdog recovers from a controller that never completes. Sits between the system-side DAC clients and the controller's `msg_*` interface.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `TIMEOUT_CC`, 4096: watchdog limit in clock cycles, counted from message capture to `ctrl_done_i`; legal range ≥ 4.
- `EMERG_CMD`, 4'b0101: command issued on over-temperature (power down chip).
- `LOCK_AFTER_EMERG`, 1: when 1, requesters are blocked after an emergency until `clear_i`.
---
- `clk_i`  in  1  single clock for the whole block.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-requester message valid.
- `req_ready_o`  out  NUM_REQ  one-hot acceptance strobe.
- `req_cmd_i`  in  4*NUM_REQ  commands; requester i occupies bits [4i+3:4i].
- `req_mask_i`  in  8*NUM_REQ  channel masks.
- `req_data_i`  in  16*NUM_REQ  data words.
- `req_done_o`  out  NUM_REQ  one-cycle completion pulse, per requester.
- `req_err_o`  out  NUM_REQ  one-cycle error pulse, per requester.
- `msg_valid_o`  out  1  to controller `msg_valid_i`.
- `msg_ready_i`  in  1  from controller `msg_ready_o`.
- `msg_cmd_o` / `msg_chan_mask_o` / `msg_data_o`  out  4/8/16  message fields.
- `ctrl_done_i`, `ctrl_err_echo_i`, `ctrl_err_illegal_i`  in  1 each  controller status.
- `ovrtmp_irq_i`  in  1  over-temperature pulse (controller `ovrtmp_irq_o`).
- `clear_i`  in  1  clears `timeout_o` and `blocked_o`.
- `emerg_pending_o`  out  1  emergency is requested but not yet issued.
- `emerg_done_o`  out  1  one-cycle pulse when the emergency command completes.
- `blocked_o`  out  1  requesters locked out.
- `timeout_o`  out  1  sticky watchdog flag.
- `owner_o`  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- **FSM states:** `IDLE`, `ISSUE`, `WAIT`.
- **Owner tag:** the owner is either a requester index or EMERG.
- **IDLE, priority order:**
  1. If `emerg_pending_o | ovrtmp_irq_i`: capture `EMERG_CMD`, mask 0, data 0. No `req_ready_o` is asserted. Go to `ISSUE`.
  2. Else, if `!blocked_o` and any `req_valid_i`: pick the winner round-robin, searching from `ptr+1` upward with wrap. Assert `req_ready_o[winner]` combinationally in that cycle. Capture the winner's fields, set `ptr = winner` and `owner_o = winner`. Go to `ISSUE`.
- **ISSUE:**
  - Hold `msg_valid_o = 1` with fields stable.
  - On `msg_valid_o & msg_ready_i`, go to `WAIT`.
  - On that same handshake cycle, sample `err_base = {ctrl_err_echo_i, ctrl_err_illegal_i}`.
- **WAIT:** on `ctrl_done_i`:
  - Pulse `req_done_o[owner]`, or `emerg_done_o` if the owner is EMERG.
  - Pulse `req_err_o[owner]` if either controller error is 1 now while its `err_base` bit was 0.
  - Return to `IDLE`.
- **`ctrl_done_i` outside `WAIT`:** ignored.
- **Emergency:**
  - `emerg_pending_o` sets on `ovrtmp_irq_i`.
  - It clears when the emergency message is captured.
  - An irq arriving while an emergency is pending or in flight is merged (no second command).
  - An emergency never preempts a transaction in flight.
  - On completion, `blocked_o` sets if `LOCK_AFTER_EMERG = 1`.
- **Watchdog:**
  - The counter resets on capture and increments in `ISSUE` and `WAIT`.
  - On reaching `TIMEOUT_CC`: deassert `msg_valid_o` (deliberate handshake abandonment), pulse `req_err_o[owner]` (or `emerg_done_o` for EMERG), and set `timeout_o`. Go to `IDLE`.
- **Flag priority:** a set event beats `clear_i` in the same cycle.
- **Reset:**
  - All outputs are 0; `msg_*` fields are 0.
  - State is `IDLE`, `ptr = NUM_REQ-1` (so requester 0 wins first), and the counter is 0.
  - A reset in mid-transaction abandons it silently, with no done or err pulse.

## Timing
- **Capture to issue:** request captured in cycle T (`req_ready_o` high) → `msg_valid_o` high from T+1.
- **Done to next grant:** `ctrl_done_i` at cycle D → `req_done_o` pulse at D+1, and the FSM is in `IDLE` at D+1. The earliest next grant is D+1, giving one dead cycle between controller messages.
- **Emergency latency:** `ovrtmp_irq_i` in cycle t → `emerg_pending_o` high at t+1, unless the FSM was in `IDLE` at t, in which case capture happens at t.
- **Output registering:** `req_done_o`, `req_err_o`, `emerg_done_o` and the flags are registered. `req_ready_o` is the only combinational output.

## Test plan
- **Single request:** req1 sends cmd 0011, mask 0x05, data 0x8000. Required: `msg_*` carries exactly those values; `req_done_o[1]` pulses one cycle after `ctrl_done_i`; `owner_o = 1`.
- **Round-robin fairness:** all four `req_valid_i` are held high for 5 transactions. Required grant order is 0,1,2,3,0, and no `req_ready_o` ever has more than one bit set.
- **Emergency during WAIT:** `ovrtmp_irq_i` pulses while req2 is in `WAIT`. Required:
  - req2 completes normally.
  - Next, cmd 0101, mask 0x00, data 0x0000 is issued.
  - `emerg_done_o` pulses and `blocked_o = 1`.
  - req3 stalls until `clear_i`, then is granted.
- **Watchdog:** set `TIMEOUT_CC = 64` and never assert `ctrl_done_i` after acceptance. Required: exactly 64 cycles after capture, `req_err_o[owner]` pulses, `timeout_o = 1` and the FSM returns to `IDLE`. `clear_i` then clears `timeout_o`.
- **Error edge detection:** `ctrl_err_echo_i` rises during req0's transaction. Required: `req_done_o[0]` and `req_err_o[0]` both pulse. A following req1 transaction, with the error still high, produces no `req_err_o`.
- **Reset mid-transaction:** assert `rst_i` in `WAIT`. Required: all outputs read 0 the next cycle, and the first grant after reset goes to requester 0.
